mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_TIMEOUT, default 8: idle cycles a locked owner may hold the port before forced release.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 Port: clk  in  1  rising-edge clock shared with mem.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Ports per requester k in {0,1}: rk_req  in  1  access request, held until granted.
REQ-006 Ports per requester: rk_we  in  1  1=write, 0=read.
REQ-007 Ports per requester: rk_lock  in  1  keep ownership after this access.
REQ-008 Ports per requester: rk_addr  in  16  byte address of big-endian 16-bit word.
REQ-009 Ports per requester: rk_wdata  in  16  write word.
REQ-010 Ports per requester: rk_gnt  out  1  one-cycle pulse, access performed this cycle.
REQ-011 Ports per requester: rk_rvalid  out  1  read data valid, one cycle.
REQ-012 Ports per requester: rk_rdata  out  16  registered read word.
REQ-013 Memory side: m_raddr  out  16  to mem data read address.
REQ-014 Memory side: m_rdata  in  16  combinational read word from mem.
REQ-015 Memory side: m_wen, m_waddr, m_wdata  out  1/16/16  to mem write port.

Function
REQ-016 At most one rk_gnt SHALL be high per cycle; rk_gnt SHALL be combinational from current req and state.
REQ-017 Read grant: m_raddr = rk_addr in the grant cycle; m_rdata SHALL be registered into rk_rdata; rk_rvalid high exactly the next cycle (latency 1).
REQ-018 Write grant: m_wen=1, m_waddr=rk_addr, m_wdata=rk_wdata in the grant cycle only; m_wen=0 otherwise.
REQ-019 rk_rdata SHALL hold its last value when rk_rvalid is low.
REQ-020 Odd addresses and 0xFFFF SHALL be passed unmodified (mem wraps addr+1 to 0x0000).
REQ-021 States: IDLE, LOCK0, LOCK1.
REQ-022 IDLE: single requester granted immediately; both requesting -> round-robin pointer decides; pointer SHALL move to the other requester after every grant.
REQ-023 IDLE -> LOCKk when requester k granted with rk_lock=1; counter cleared.
REQ-024 LOCKk: only requester k granted; other requester waits with req held; pointer unchanged.
REQ-025 LOCKk -> IDLE when k is granted with rk_lock=0.
REQ-026 LOCKk: counter increments each cycle rk_req=0, clears on each grant; counter reaching LOCK_TIMEOUT SHALL force IDLE and set pointer to the other requester.
REQ-027 Forced release with other requester pending: grant to other requester in the first IDLE cycle.
REQ-028 Back-to-back grants to the same requester SHALL be allowed when the other does not request.

Reset
REQ-029 With rst_n=0 at a clock edge: state IDLE, pointer=requester 0, counter 0, rk_rvalid=0, rk_rdata=0x0000.
REQ-030 During rst_n=0, all rk_gnt and m_wen SHALL be 0 combinationally; a read granted the cycle before reset SHALL NOT produce rvalid.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum, ADDR_W=16, DATA_W=16, requester index constants.
REQ-032 One sub-module rr_pick2 (2-way round-robin picker: req[1:0], ptr -> onehot grant) SHALL be used.

Verification
REQ-033 Mem preloaded 0x0010=0xAB,0x0011=0xCD; r0 read 0x0010 -> r0_gnt cycle N, r0_rvalid N+1, r0_rdata=0xABCD.
REQ-034 r0 and r1 request reads every cycle -> grants alternate 0,1,0,1; no cycle with both gnt.
REQ-035 r1 write 0xFFFF data 0x1234 -> m_wen one cycle; mem[0xFFFF]=0x12, mem[0x0000]=0x34; r0 read 0xFFFF next -> 0x1234.
REQ-036 r0 read lock=1, r1 pending, r0 write lock=0 two cycles later -> r1 granted only after r0 write; RMW intact.
REQ-037 r0 locks then idles, r1 pending, LOCK_TIMEOUT=8 -> r1 granted in first IDLE cycle after timeout; later r0/r1 contention grants r0 first.
REQ-038 rst_n low in cycle after read grant -> no rvalid, rdata=0x0000, state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Bus widths, requester indices and the lock FSM encoding live here.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter bundled in one interface.
// master = environment (requesters plus memory), slave = the arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              r0_req;
    logic              r0_we;
    logic              r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic              r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] m_raddr;
    logic [DATA_W-1:0] m_rdata;
    logic              m_wen;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  m_raddr, m_wen, m_waddr, m_wdata,
        output m_rdata
    );

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output m_raddr, m_wen, m_waddr, m_wdata,
        input  m_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, on contention
// ptr names the winner. Output is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves gnt unassigned (no latch).
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-cycle memory port, with
// round-robin fairness and an optional bus lock that times out when idle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t        state;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        req_vec;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              owner_lock;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign req_vec = {bus.r1_req, bus.r0_req};

    rr_pick2 u_pick (
        .req (req_vec),
        .ptr (ptr),
        .gnt (pick)
    );

    // Reset masks every grant so no access can reach the memory while rst_n is low.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (state)
                IDLE:    gnt = pick;
                LOCK0:   gnt[REQ0] = bus.r0_req;
                LOCK1:   gnt[REQ1] = bus.r1_req;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign owner_lock = (state == LOCK1) ? bus.r1_lock : bus.r0_lock;

    assign bus.r0_gnt  = gnt[REQ0];
    assign bus.r1_gnt  = gnt[REQ1];
    assign bus.m_raddr = gnt[REQ1] ? bus.r1_addr  : bus.r0_addr;
    assign bus.m_waddr = gnt[REQ1] ? bus.r1_addr  : bus.r0_addr;
    assign bus.m_wdata = gnt[REQ1] ? bus.r1_wdata : bus.r0_wdata;
    assign bus.m_wen   = (gnt[REQ0] & bus.r0_we) | (gnt[REQ1] & bus.r1_we);

    // rvalid is also masked by rst_n so a read granted just before reset never reports.
    assign bus.r0_rvalid = rvalid_q[REQ0] & rst_n;
    assign bus.r1_rvalid = rvalid_q[REQ1] & rst_n;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            cnt      <= '0;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= {gnt[REQ1] & ~bus.r1_we, gnt[REQ0] & ~bus.r0_we};
            if (gnt[REQ0] && !bus.r0_we) rdata0_q <= bus.m_rdata;
            if (gnt[REQ1] && !bus.r1_we) rdata1_q <= bus.m_rdata;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gnt[REQ0]) begin
                        ptr <= 1'b1;
                        if (bus.r0_lock) state <= LOCK0;
                    end else if (gnt[REQ1]) begin
                        ptr <= 1'b0;
                        if (bus.r1_lock) state <= LOCK1;
                    end
                end
                LOCK0, LOCK1: begin
                    if (gnt != 2'b00) begin
                        cnt <= '0;
                        if (!owner_lock) state <= IDLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        // Idle owner timed out: hand priority to the waiting side.
                        cnt   <= '0;
                        state <= IDLE;
                        ptr   <= (state == LOCK0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, wrap-around write, round-robin
// contention, locked read-modify-write, lock timeout and reset mid-read.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] raddr_p1;

    mem_arbiter_if bus ();

    mem_arbiter #(.LOCK_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed big-endian memory; the low byte of 0xFFFF lives at 0x0000.
    assign raddr_p1    = bus.m_raddr + 16'd1;
    assign bus.m_rdata = {mem[bus.m_raddr], mem[raddr_p1]};

    initial begin
        logic [15:0] waddr_p1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hAB;
        mem[16'h0011] = 8'hCD;
        mem[16'h0020] = 8'h55;
        mem[16'h0021] = 8'h66;
        forever begin
            @(posedge clk);
            if (bus.m_wen) begin
                waddr_p1 = bus.m_waddr + 16'd1;
                mem[bus.m_waddr] = bus.m_wdata[15:8];
                mem[waddr_p1]    = bus.m_wdata[7:0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_r0(input logic req, input logic we, input logic lock,
                          input logic [15:0] addr, input logic [15:0] wdata);
        bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
        bus.r0_addr = addr; bus.r0_wdata = wdata;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic lock,
                          input logic [15:0] addr, input logic [15:0] wdata);
        bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
        bus.r1_addr = addr; bus.r1_wdata = wdata;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic e0;
        rst_n = 1'b0;
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset are masked combinationally.
        set_r0(1, 1, 0, 16'h0010, 16'h1111);
        set_r1(1, 0, 0, 16'h0020, 16'h0000);
        smp();
        check("rst_gnt0", bus.r0_gnt, 0);
        check("rst_gnt1", bus.r1_gnt, 0);
        check("rst_wen", bus.m_wen, 0);
        cyc();
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        check("rst_rvalid0", bus.r0_rvalid, 0);
        check("rst_rdata0", bus.r0_rdata, 16'h0000);
        check("rst_rdata1", bus.r1_rdata, 16'h0000);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;

        // r0 reads 0x0010: grant now, data one cycle later, then held.
        cyc();
        set_r0(1, 0, 0, 16'h0010, 16'h0000);
        smp();
        check("rd_gnt0", bus.r0_gnt, 1);
        check("rd_gnt1", bus.r1_gnt, 0);
        check("rd_raddr", bus.m_raddr, 16'h0010);
        check("rd_wen", bus.m_wen, 0);
        cyc();
        set_r0(0, 0, 0, 16'h0010, 16'h0000);
        smp();
        check("rd_gnt0_off", bus.r0_gnt, 0);
        check("rd_rvalid", bus.r0_rvalid, 1);
        check("rd_rdata", bus.r0_rdata, 16'hABCD);
        cyc();
        smp();
        check("rd_rvalid_off", bus.r0_rvalid, 0);
        check("rd_rdata_hold", bus.r0_rdata, 16'hABCD);

        // r1 writes 0x1234 at 0xFFFF; the low byte wraps to 0x0000.
        cyc();
        set_r1(1, 1, 0, 16'hFFFF, 16'h1234);
        smp();
        check("wr_gnt1", bus.r1_gnt, 1);
        check("wr_gnt0", bus.r0_gnt, 0);
        check("wr_wen", bus.m_wen, 1);
        check("wr_waddr", bus.m_waddr, 16'hFFFF);
        check("wr_wdata", bus.m_wdata, 16'h1234);
        cyc();
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("wr_wen_off", bus.m_wen, 0);
        check("wr_no_rvalid", bus.r1_rvalid, 0);
        check("wr_mem_ffff", mem[16'hFFFF], 8'h12);
        check("wr_mem_0000", mem[16'h0000], 8'h34);

        cyc();
        set_r0(1, 0, 0, 16'hFFFF, 16'h0000);
        smp();
        check("wrap_gnt0", bus.r0_gnt, 1);
        check("wrap_raddr", bus.m_raddr, 16'hFFFF);
        cyc();
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("wrap_rvalid", bus.r0_rvalid, 1);
        check("wrap_rdata", bus.r0_rdata, 16'h1234);

        // Single r1 read leaves the pointer on r0.
        cyc();
        set_r1(1, 0, 0, 16'h0020, 16'h0000);
        smp();
        check("r1rd_gnt1", bus.r1_gnt, 1);
        cyc();
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("r1rd_rvalid", bus.r1_rvalid, 1);
        check("r1rd_rdata", bus.r1_rdata, 16'h5566);
        check("r1rd_r0_hold", bus.r0_rdata, 16'h1234);

        // Continuous contention alternates 0,1,0,1.
        cyc();
        set_r0(1, 0, 0, 16'h0010, 16'h0000);
        set_r1(1, 0, 0, 16'h0020, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            smp();
            check("cont_gnt0", bus.r0_gnt, 32'(e0));
            check("cont_gnt1", bus.r1_gnt, 32'(!e0));
            if (i > 0) begin
                check("cont_rvalid0", bus.r0_rvalid, 32'(!e0));
                check("cont_rvalid1", bus.r1_rvalid, 32'(e0));
            end
            cyc();
        end
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("cont_last_rvalid1", bus.r1_rvalid, 1);
        check("cont_last_rdata1", bus.r1_rdata, 16'h5566);
        check("cont_last_rvalid0", bus.r0_rvalid, 0);

        // Locked read-modify-write by r0 while r1 waits with a write.
        cyc();
        set_r0(1, 0, 1, 16'h0010, 16'h0000);
        set_r1(1, 1, 0, 16'h0030, 16'hBEEF);
        smp();
        check("rmw_rd_gnt0", bus.r0_gnt, 1);
        check("rmw_rd_gnt1", bus.r1_gnt, 0);
        cyc();
        set_r0(0, 0, 0, 16'h0010, 16'h0000);
        smp();
        check("rmw_wait_gnt1", bus.r1_gnt, 0);
        check("rmw_rvalid", bus.r0_rvalid, 1);
        check("rmw_rdata", bus.r0_rdata, 16'hABCD);
        check("rmw_state", 32'(dut.state), 32'(LOCK0));
        cyc();
        set_r0(1, 1, 0, 16'h0010, 16'hABCE);
        smp();
        check("rmw_wr_gnt0", bus.r0_gnt, 1);
        check("rmw_wr_gnt1", bus.r1_gnt, 0);
        check("rmw_wr_wen", bus.m_wen, 1);
        check("rmw_wr_wdata", bus.m_wdata, 16'hABCE);
        cyc();
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("rmw_r1_gnt", bus.r1_gnt, 1);
        check("rmw_r1_waddr", bus.m_waddr, 16'h0030);
        check("rmw_idle", 32'(dut.state), 32'(IDLE));
        cyc();
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("rmw_mem_0011", mem[16'h0011], 8'hCE);
        check("rmw_mem_0031", mem[16'h0031], 8'hEF);

        // r0 locks then goes quiet; after 8 idle lock cycles r1 is served.
        cyc();
        set_r0(1, 0, 1, 16'h0020, 16'h0000);
        set_r1(1, 0, 0, 16'h0010, 16'h0000);
        smp();
        check("to_lock_gnt0", bus.r0_gnt, 1);
        cyc();
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            smp();
            check("to_wait_gnt1", bus.r1_gnt, 0);
            if (k == 1) check("to_rdata0", bus.r0_rdata, 16'h5566);
            if (k == 8) check("to_still_locked", 32'(dut.state), 32'(LOCK0));
            cyc();
        end
        smp();
        check("to_release_gnt1", bus.r1_gnt, 1);
        check("to_release_state", 32'(dut.state), 32'(IDLE));
        cyc();
        set_r0(1, 0, 0, 16'h0010, 16'h0000);
        set_r1(1, 0, 0, 16'h0020, 16'h0000);
        smp();
        check("to_r1_rvalid", bus.r1_rvalid, 1);
        check("to_r1_rdata", bus.r1_rdata, 16'hABCE);
        check("to_after_gnt0", bus.r0_gnt, 1);
        check("to_after_gnt1", bus.r1_gnt, 0);
        cyc();
        smp();
        check("to_next_gnt1", bus.r1_gnt, 1);
        cyc();

        // Reset asserted in the cycle after a read grant.
        set_r0(1, 0, 0, 16'h0010, 16'h0000);
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("rr_gnt0", bus.r0_gnt, 1);
        cyc();
        rst_n = 1'b0;
        set_r0(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("rr_rvalid_masked", bus.r0_rvalid, 0);
        cyc();
        check("rr_rvalid", bus.r0_rvalid, 0);
        check("rr_rdata0", bus.r0_rdata, 16'h0000);
        check("rr_rdata1", bus.r1_rdata, 16'h0000);
        check("rr_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        cyc();
        set_r1(1, 0, 0, 16'h0020, 16'h0000);
        smp();
        check("post_rst_gnt1", bus.r1_gnt, 1);
        cyc();
        set_r1(0, 0, 0, 16'h0000, 16'h0000);
        smp();
        check("post_rst_rdata1", bus.r1_rdata, 16'h5566);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
